pll_share_sequencer: RTL and testbench

PLL_SHARE_SEQUENCER -- requirements
Module: pll_share_sequencer

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/pll_lock_sync.sv | 22 ++
 rtl/pll_share_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pll_share_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and widths for the PLL share sequencer.
package pll_seq_pkg;

  // Number of power-down requesters sharing the PLL (A = 0, B = 1).
  localparam int NUM_REQ = 2;

  // Sequencer state encoding, also exported on the optional status port.
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_PD        = 3'd0,
    ST_MCGB      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  // Widths of the optional status counters.
  localparam int RETRY_STAT_W = 4;
  localparam int RELOCK_W     = 8;

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer for the asynchronous PLL lock input.
module pll_lock_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_share_sequencer.sv
// pll_share_sequencer: power-up/lock sequencer for a PLL shared by two
// requesters. Holds power-down, then MCGB reset, then waits for a stable
// lock with timeout/retry, and reports qualified lock per requester.
// Optional status outputs (seq_state, retry_cnt, relock_cnt) are built
// when PLL_SEQ_STATUS_EN is defined.
module pll_share_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PD_HOLD_CYCLES      = 64,
  parameter int MCGB_HOLD_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 32,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int MAX_RETRIES         = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic pll_powerdown_a,
  input  logic pll_powerdown_b,
  output logic pll_powerdown,
  output logic mcgb_rst,
  output logic pll_locked_a,
  output logic pll_locked_b,
  output logic pll_fail
`ifdef PLL_SEQ_STATUS_EN
  ,
  output logic [STATE_W-1:0]      seq_state,
  output logic [RETRY_STAT_W-1:0] retry_cnt,
  output logic [RELOCK_W-1:0]     relock_cnt
`endif
);

  localparam int PD_W    = $clog2(PD_HOLD_CYCLES + 1);
  localparam int MCGB_W  = $clog2(MCGB_HOLD_CYCLES + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int LOSS_W  = $clog2(LOSS_FILTER_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  seq_state_e state_q, state_d;

  logic                 lock_s;
  logic [NUM_REQ-1:0]   req, req_q, rise, lk_q;
  logic                 req_any, rise_any;

  logic [PD_W-1:0]      pd_cnt;
  logic [MCGB_W-1:0]    mcgb_cnt;
  logic [STAB_W-1:0]    stab_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [LOSS_W-1:0]    loss_cnt;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic pd_done, mcgb_done, stable_done, timeout, loss_done;

  pll_lock_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign req      = {pll_powerdown_b, pll_powerdown_a};
  assign rise     = req & ~req_q;
  assign req_any  = |req;
  // Simultaneous A/B edges collapse into a single restart here.
  assign rise_any = |rise;

  // Counters hold completed cycles in the state, so "done" fires on the
  // last cycle of the hold and the transition lands exactly on the count.
  assign pd_done     = int'(pd_cnt)   >= PD_HOLD_CYCLES - 1;
  assign mcgb_done   = int'(mcgb_cnt) >= MCGB_HOLD_CYCLES - 1;
  assign stable_done = lock_s  && (int'(stab_cnt) >= LOCK_STABLE_CYCLES - 1);
  assign timeout     = int'(to_cnt)   >= LOCK_TIMEOUT_CYCLES - 1;
  assign loss_done   = !lock_s && (int'(loss_cnt) >= LOSS_FILTER_CYCLES - 1);

  // State, request history and retry count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PD;
      req_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; a requester edge outranks timeout and lock detection.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_PD: begin
        if (!req_any && pd_done) state_d = ST_MCGB;
      end
      ST_MCGB: begin
        if (rise_any)       state_d = ST_PD;
        else if (mcgb_done) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (rise_any) begin
          state_d = ST_PD;
        end else if (stable_done) begin
          state_d = ST_LOCKED;
          retry_d = '0;
        end else if (timeout) begin
          if (int'(retry_q) < MAX_RETRIES) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_PD;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        if (rise_any || loss_done) state_d = ST_PD;
      end
      ST_FAIL: begin
        if (rise_any) begin
          state_d = ST_PD;
          retry_d = '0;
        end
      end
      default: state_d = ST_PD;
    endcase
  end

  // Per-state saturating counters, all cleared on any state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pd_cnt   <= '0;
      mcgb_cnt <= '0;
      stab_cnt <= '0;
      to_cnt   <= '0;
      loss_cnt <= '0;
    end else if (state_d != state_q) begin
      pd_cnt   <= '0;
      mcgb_cnt <= '0;
      stab_cnt <= '0;
      to_cnt   <= '0;
      loss_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_PD: begin
          // Any request level restarts the power-down hold.
          if (req_any)                             pd_cnt <= '0;
          else if (int'(pd_cnt) < PD_HOLD_CYCLES)  pd_cnt <= pd_cnt + 1'b1;
        end
        ST_MCGB: begin
          if (int'(mcgb_cnt) < MCGB_HOLD_CYCLES) mcgb_cnt <= mcgb_cnt + 1'b1;
        end
        ST_WAIT_LOCK: begin
          if (int'(to_cnt) < LOCK_TIMEOUT_CYCLES) to_cnt <= to_cnt + 1'b1;
          if (!lock_s)                                     stab_cnt <= '0;
          else if (int'(stab_cnt) < LOCK_STABLE_CYCLES)    stab_cnt <= stab_cnt + 1'b1;
        end
        ST_LOCKED: begin
          if (lock_s)                                      loss_cnt <= '0;
          else if (int'(loss_cnt) < LOSS_FILTER_CYCLES)    loss_cnt <= loss_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-requester lock qualifier: registered from "locked and not requesting
  // power-down", then gated by the live state so it drops on the exit edge.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lk
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lk_q[i] <= 1'b0;
      else          lk_q[i] <= (state_q == ST_LOCKED) && !req[i];
    end
  end

  assign pll_locked_a  = lk_q[0] && (state_q == ST_LOCKED);
  assign pll_locked_b  = lk_q[1] && (state_q == ST_LOCKED);
  assign pll_powerdown = (state_q == ST_PD) || (state_q == ST_FAIL);
  assign mcgb_rst      = (state_q == ST_PD) || (state_q == ST_MCGB) || (state_q == ST_FAIL);
  assign pll_fail      = (state_q == ST_FAIL);

`ifdef PLL_SEQ_STATUS_EN
  logic [RELOCK_W-1:0] relock_q;

  // Count LOCKED -> PD exits, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      relock_q <= '0;
    else if (state_q == ST_LOCKED && state_d == ST_PD && relock_q != '1)
      relock_q <= relock_q + 1'b1;
  end

  assign seq_state  = state_q;
  assign retry_cnt  = RETRY_STAT_W'(retry_q);
  assign relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_pll_share_sequencer.sv
// tb_pll_share_sequencer: directed + randomized bench for pll_share_sequencer
// with a timestamp-based reference model of the sequencing rules.
module tb_pll_share_sequencer;

  localparam int PDH  = 64;
  localparam int MCH  = 16;
  localparam int STB  = 32;
  localparam int TMO  = 4096;
  localparam int LOSS = 4;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  logic reset_n, pll_locked, pll_powerdown_a, pll_powerdown_b;
  logic pll_powerdown, mcgb_rst, pll_locked_a, pll_locked_b, pll_fail;
`ifdef PLL_SEQ_STATUS_EN
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;
`endif

  pll_share_sequencer #(
    .PD_HOLD_CYCLES      (PDH),
    .MCGB_HOLD_CYCLES    (MCH),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOSS_FILTER_CYCLES  (LOSS),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .pll_powerdown_a (pll_powerdown_a),
    .pll_powerdown_b (pll_powerdown_b),
    .pll_powerdown   (pll_powerdown),
    .mcgb_rst        (mcgb_rst),
    .pll_locked_a    (pll_locked_a),
    .pll_locked_b    (pll_locked_b),
    .pll_fail        (pll_fail)
`ifdef PLL_SEQ_STATUS_EN
    ,
    .seq_state       (seq_state),
    .retry_cnt       (retry_cnt),
    .relock_cnt      (relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: phase plus timestamps of the relevant events.
  typedef enum int {M_PD = 0, M_MCGB = 1, M_WAIT = 2, M_LOCKED = 3, M_FAIL = 4} mph_e;
  mph_e ph;
  int   cyc, s, last_req, last_lo, last_hi, retries, relocks;
  bit   pa, pb, r1, r2, m_lka, m_lkb;

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  task automatic model_reset();
    cyc = 0; ph = M_PD; s = 0; last_req = -1; last_lo = 0; last_hi = 0;
    retries = 0; relocks = 0; pa = 0; pb = 0; r1 = 0; r2 = 0; m_lka = 0; m_lkb = 0;
  endtask

  // Evaluate one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit   ls, rise;
    mph_e nph;
    cyc++;
    ls = r2; r2 = r1; r1 = pll_locked;  // lock seen two edges late
    rise = (pll_powerdown_a && !pa) || (pll_powerdown_b && !pb);
    if (ls) last_hi = cyc; else last_lo = cyc;
    nph = ph;
    case (ph)
      M_PD:     if (pll_powerdown_a || pll_powerdown_b) last_req = cyc;
                else if (cyc - imax(s, last_req) >= PDH) nph = M_MCGB;
      M_MCGB:   if (rise) nph = M_PD;
                else if (cyc - s >= MCH) nph = M_WAIT;
      M_WAIT:   if (rise) nph = M_PD;
                else if (ls && cyc - imax(s, last_lo) >= STB) begin nph = M_LOCKED; retries = 0; end
                else if (cyc - s >= TMO) begin
                  if (retries < MAXR) begin retries++; nph = M_PD; end
                  else nph = M_FAIL;
                end
      M_LOCKED: if (rise || (!ls && cyc - imax(s, last_hi) >= LOSS)) nph = M_PD;
      M_FAIL:   if (rise) begin nph = M_PD; retries = 0; end
      default:  nph = M_PD;
    endcase
    if (ph == M_LOCKED && nph == M_PD && relocks < 255) relocks++;
    m_lka = (ph == M_LOCKED) && (nph == M_LOCKED) && !pll_powerdown_a;
    m_lkb = (ph == M_LOCKED) && (nph == M_LOCKED) && !pll_powerdown_b;
    pa = pll_powerdown_a; pb = pll_powerdown_b;
    if (nph != ph) begin ph = nph; s = cyc; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance DUT and model, then compare all outputs.
  task automatic step();
    logic [4:0] obs, exp;
    @(posedge clk);
    model_edge();
    #1;
    exp = {ph == M_PD || ph == M_FAIL, ph != M_WAIT && ph != M_LOCKED, m_lka, m_lkb, ph == M_FAIL};
    obs = {pll_powerdown, mcgb_rst, pll_locked_a, pll_locked_b, pll_fail};
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL outputs cyc %0d: observed %b expected %b", cyc, obs, exp);
    end
`ifdef PLL_SEQ_STATUS_EN
    ncmp++;
    assert ({seq_state, retry_cnt, relock_cnt} === {3'(ph), 4'(retries), 8'(relocks)}) else begin
      nfail++;
      $error("FAIL status cyc %0d: observed %0d/%0d/%0d expected %0d/%0d/%0d",
             cyc, seq_state, retry_cnt, relock_cnt, ph, retries, relocks);
    end
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({pll_powerdown, mcgb_rst, pll_locked_a, pll_locked_b, pll_fail}), 32'h18);
`ifdef PLL_SEQ_STATUS_EN
    chk("reset_status", 32'({seq_state, retry_cnt, relock_cnt}), 0);
`endif
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_lock_a(input string tag, input int bound);
    int n = 0;
    while (!pll_locked_a && n < bound) begin step(); n++; end
    chk(tag, 32'(pll_locked_a), 1);
  endtask

  task automatic run_to_fail(input string tag);
    int  n = 0, nw = 0;
    logic pm = mcgb_rst;
    while (!pll_fail && n < 4 * (PDH + MCH + TMO) + 400) begin
      step(); n++;
      if (pm && !mcgb_rst) nw++;
      pm = mcgb_rst;
    end
    chk({tag, "_wait_entries"}, 32'(nw), 4);
    chk({tag, "_fail"}, 32'(pll_fail), 1);
    chk({tag, "_pd"}, 32'(pll_powerdown), 1);
  endtask

  int  t_pd, t_mc, t_lk, idx, n;
  bit  bad, seen, lk_at, lk_before, prevlk;

  initial begin
    reset_n = 1'b1; pll_locked = 1'b1; pll_powerdown_a = 1'b0; pll_powerdown_b = 1'b0;
    #3;
    do_reset();

    // Power-up with lock tied high: release points are fixed by the holds.
    t_pd = -1; t_mc = -1; t_lk = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (t_pd < 0 && !pll_powerdown) t_pd = cyc;
      if (t_mc < 0 && !mcgb_rst) t_mc = cyc;
      if (t_lk < 0 && pll_locked_a && pll_locked_b) t_lk = cyc;
    end
    chk("pd_release_cyc", 32'(t_pd), 64);
    chk("mcgb_release_cyc", 32'(t_mc), 80);
    chk("lock_within_35", 32'(t_lk > 80 && t_lk <= 80 + STB + 3), 1);

    // Three-cycle lock glitch is filtered.
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      pll_locked = (i >= 3);
      step();
      if (!pll_locked_a || !pll_locked_b || pll_powerdown) bad = 1;
    end
    chk("glitch3_held", 32'(bad), 0);

    // Four-cycle drop is a loss: PD and lock flags change on the same cycle.
    seen = 0; lk_at = 1; lk_before = 0; idx = -1;
    for (int i = 0; i < 12; i++) begin
      pll_locked = (i >= 4);
      prevlk = pll_locked_a && pll_locked_b;
      step();
      if (pll_powerdown && !seen) begin
        seen = 1; idx = i; lk_at = pll_locked_a || pll_locked_b; lk_before = prevlk;
      end
    end
    chk("loss4_pd_entered", 32'(seen), 1);
    chk("loss4_latency", 32'(idx), 5);
    chk("loss4_lock_cleared", 32'(lk_at), 0);
    chk("loss4_lock_before", 32'(lk_before), 1);

    // Randomized segments of lock behaviour and requester pulses.
    for (int seg = 0; seg < 25; seg++) begin
      int len  = $urandom_range(40, 400);
      int mode = $urandom % 3;
      if (seg == 10) begin
        pll_powerdown_a = 0; pll_powerdown_b = 0;
        do_reset();
      end
      for (int i = 0; i < len; i++) begin
        pll_locked = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom % 16 != 0);
        pll_powerdown_a = ($urandom % 250 == 0) ? 1'b1 : (pll_powerdown_a && ($urandom % 3 != 0));
        pll_powerdown_b = ($urandom % 250 == 0) ? 1'b1 : (pll_powerdown_b && ($urandom % 3 != 0));
        if ($urandom % 400 == 0) begin pll_powerdown_a = 1; pll_powerdown_b = 1; end
        step();
      end
    end
    pll_powerdown_a = 0; pll_powerdown_b = 0;

    // Requester B holds power-down from LOCKED; B never reports lock meanwhile.
    pll_locked = 1;
    wait_lock_a("b_pre_locked", 400);
    pll_powerdown_b = 1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!pll_powerdown) bad = 1;
    end
    chk("b_hold_pd", 32'(bad), 0);
    pll_powerdown_b = 0;
    seen = 0; n = 0;
    while (!pll_locked_a && n < 400) begin
      step(); n++;
      if (pll_locked_b && !pll_locked_a) seen = 1;
    end
    chk("b_rerun_locked_a", 32'(pll_locked_a), 1);
    chk("b_no_early_lock", 32'(seen), 0);

    // No lock at all: retries exhaust and FAIL is reached.
    pll_locked = 0;
    run_to_fail("timeout1");
    pll_powerdown_a = 1;
    step();
    pll_powerdown_a = 0;
    chk("fail_exit_fail", 32'(pll_fail), 0);
    chk("fail_exit_pd", 32'(pll_powerdown), 1);

    // Both requesters rise on the timeout cycle: one PD entry, retries kept.
    n = 0;
    while (!(ph == M_WAIT && cyc - s == TMO - 1) && n < TMO + 400) begin step(); n++; end
    pll_powerdown_a = 1; pll_powerdown_b = 1;
    step();
    pll_powerdown_a = 0; pll_powerdown_b = 0;
    chk("ab_timeout_pd", 32'(pll_powerdown), 1);
    chk("ab_timeout_nofail", 32'(pll_fail), 0);
    run_to_fail("timeout2");
    pll_powerdown_a = 1;
    step();
    pll_powerdown_a = 0;

`ifdef PLL_SEQ_STATUS_EN
    // Relock counter: two events, then saturation.
    do_reset();
    pll_locked = 1;
    for (int k = 1; k <= 300; k++) begin
      wait_lock_a("relock_lock", 300);
      pll_locked = 0;
      n = 0;
      while (!pll_powerdown && n < 20) begin step(); n++; end
      pll_locked = 1;
      if (k == 2) chk("relock_2", 32'(relock_cnt), 2);
      if (nfail != 0) break;
    end
    chk("relock_sat", 32'(relock_cnt), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
